// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, core redirect and instruction delivery.
// master = fetch_unit side, slave = memory/core environment side.
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
  logic        fault_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_ack_i, imem_rdata_i,
    input  redirect_i, redirect_pc_i,
    output inst_valid_o, inst_o, inst_pc_o,
    input  inst_ready_i,
    output fault_o
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_ack_i, imem_rdata_i,
    output redirect_i, redirect_pc_i,
    input  inst_valid_o, inst_o, inst_pc_o,
    output inst_ready_i,
    input  fault_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher feeding a FIFO_DEPTH buffer; data reaches the head the cycle after ack.
// Stops requesting while the buffer is full; FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic          clock_i,
  input logic          reset_n_i,
  fetch_unit_if.master bus
);
  localparam int            AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_addr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_buf_inst [FIFO_DEPTH];
  logic [31:0]   r_buf_pc   [FIFO_DEPTH];

  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_halt;
  logic [31:0]   w_redirect_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;

  assign w_redirect_pc = bus.redirect_pc_i;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_fault <= 1'b0;
    end else if (bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00)) begin
      r_fault <= 1'b1;
    end
  end

  assign w_halt      = r_fault;
  assign bus.fault_o = r_fault;
`else
  assign w_redirect_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
  assign w_halt        = 1'b0;
  assign bus.fault_o   = 1'b0;
`endif

  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && bus.inst_ready_i && !bus.redirect_i;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A redirect seen in IDLE holds off the issue so the new target is what gets requested.
  always_comb begin
    w_state_nxt    = r_state;
    w_issue        = 1'b0;
    w_push         = 1'b0;
    bus.imem_req_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.redirect_i && !w_halt && (r_count < DEPTH_C)) begin
          w_state_nxt = S_WAIT;
          w_issue     = 1'b1;
        end
      end
      S_WAIT: begin
        bus.imem_req_o = 1'b1;
        if (bus.imem_ack_i) begin
          w_state_nxt = S_IDLE;
          w_push      = !bus.redirect_i;
        end else if (bus.redirect_i) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        bus.imem_req_o = 1'b1;
        if (bus.imem_ack_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_issue) begin
        r_req_addr <= r_fetch_pc;
      end
      if (bus.redirect_i) begin
        r_fetch_pc <= w_redirect_pc;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_push) begin
          r_fetch_pc <= r_req_addr + 32'd4;
          r_wr_ptr   <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (w_push) begin
      r_buf_inst[r_wr_ptr] <= bus.imem_rdata_i;
      r_buf_pc[r_wr_ptr]   <= r_req_addr;
    end
  end

  assign bus.imem_addr_o  = r_req_addr;
  assign bus.inst_valid_o = !w_empty;
  assign bus.inst_o       = w_empty ? NOP : r_buf_inst[r_rd_ptr];
  assign bus.inst_pc_o    = w_empty ? 32'h0000_0000 : r_buf_pc[r_rd_ptr];
endmodule
